// File: rtl/sprite_fetch_if.sv
// Sprite register read port shared between the fetch engine and the register file.
// The master requests and addresses; the slave grants and returns data combinationally.
interface sprite_fetch_if;
   logic       bus_req;
   logic       bus_gnt;
   logic [5:0] reg_addr;
   logic [7:0] reg_data;

   modport master (
      output bus_req,
      output reg_addr,
      input  bus_gnt,
      input  reg_data
   );

   modport slave (
      input  bus_req,
      input  reg_addr,
      output bus_gnt,
      output reg_data
   );
endinterface

// File: rtl/sprite_fetch.sv
// Per-frame sprite register fetch: checks the frame-ready flag on vblank,
// reads registers 0..LAST_ADDR into a shadow, then commits all sprites at once.
module sprite_fetch #(
   parameter int WORK_DONE_ADDR = 17,
   parameter int LAST_ADDR      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 vblank_start,
   sprite_fetch_if.master       bus,
   output logic [7:0]           pac_x,
   output logic [7:0]           pac_y,
   output logic [1:0]           pac_rot,
   output logic [7:0]           map_x,
   output logic [7:0]           map_y,
   output logic [31:0]          ghost_x,
   output logic [31:0]          ghost_y,
   output logic [7:0]           ghost_rot,
   output logic                 busy,
   output logic                 done,
   output logic                 skip,
   output logic                 overrun
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CHECK,
      S_FETCH,
      S_COMMIT
   } state_t;

   localparam logic [5:0] LP_WD   = 6'(WORK_DONE_ADDR);
   localparam logic [4:0] LP_LAST = 5'(LAST_ADDR);

   state_t      r_state;
   state_t      w_next;
   logic [4:0]  r_idx;
   logic [4:0]  w_idx_nxt;
   logic [7:0]  r_shadow [0:LAST_ADDR];
   logic        w_req;
   logic [5:0]  w_addr;
   logic        w_fire;
   logic        w_skip_set;

   logic        r_done;
   logic        r_skip;
   logic        r_overrun;

   logic [7:0]  r_pac_x;
   logic [7:0]  r_pac_y;
   logic [1:0]  r_pac_rot;
   logic [7:0]  r_map_x;
   logic [7:0]  r_map_y;
   logic [31:0] r_ghost_x;
   logic [31:0] r_ghost_y;
   logic [7:0]  r_ghost_rot;

   // Rotation registers only carry two meaningful bits.
   logic        w_unused;
   assign w_unused = ^{r_shadow[2][7:2], r_shadow[7][7:2],
                       r_shadow[10][7:2], r_shadow[13][7:2],
                       r_shadow[16][7:2]};

   // Next-state, read-port drive and skip detection.
   always_comb begin
      w_next     = r_state;
      w_idx_nxt  = r_idx;
      w_req      = 1'b0;
      w_addr     = 6'd0;
      w_skip_set = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (vblank_start) w_next = S_CHECK;
         end
         S_CHECK: begin
            w_req  = 1'b1;
            w_addr = LP_WD;
            if (bus.bus_gnt) begin
               if (bus.reg_data == 8'd0) begin
                  w_next     = S_IDLE;
                  w_skip_set = 1'b1;
               end else begin
                  w_next    = S_FETCH;
                  w_idx_nxt = 5'd0;
               end
            end
         end
         S_FETCH: begin
            w_req  = 1'b1;
            w_addr = {1'b0, r_idx};
            if (bus.bus_gnt) begin
               if (r_idx == LP_LAST) w_next = S_COMMIT;
               else                  w_idx_nxt = r_idx + 5'd1;
            end
         end
         S_COMMIT: begin
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_fire       = w_req & bus.bus_gnt;
   assign bus.bus_req  = w_req;
   assign bus.reg_addr = w_addr;
   assign busy         = (r_state != S_IDLE);

   // State and fetch index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_idx   <= 5'd0;
      end else begin
         r_state <= w_next;
         r_idx   <= w_idx_nxt;
      end
   end

   // Shadow capture of each granted fetch read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= LAST_ADDR; i++) r_shadow[i] <= 8'd0;
      end else if (r_state == S_FETCH && w_fire) begin
         r_shadow[r_idx] <= bus.reg_data;
      end
   end

   // Single-cycle status pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done    <= 1'b0;
         r_skip    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_done    <= (r_state == S_COMMIT);
         r_skip    <= w_skip_set;
         r_overrun <= vblank_start && (r_state != S_IDLE);
      end
   end

   // Visible sprite state updates atomically on the commit edge only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pac_x     <= 8'd0;
         r_pac_y     <= 8'd0;
         r_pac_rot   <= 2'd0;
         r_map_x     <= 8'd0;
         r_map_y     <= 8'd0;
         r_ghost_x   <= 32'd0;
         r_ghost_y   <= 32'd0;
         r_ghost_rot <= 8'd0;
      end else if (r_state == S_COMMIT) begin
         r_pac_x   <= r_shadow[0];
         r_pac_y   <= r_shadow[1];
         r_pac_rot <= r_shadow[2][1:0];
         r_map_x   <= r_shadow[3];
         r_map_y   <= r_shadow[4];
         for (int i = 0; i < 4; i++) begin
            r_ghost_x[8*i +: 8]   <= r_shadow[5 + 3*i];
            r_ghost_y[8*i +: 8]   <= r_shadow[6 + 3*i];
            r_ghost_rot[2*i +: 2] <= r_shadow[7 + 3*i][1:0];
         end
      end
   end

   assign pac_x     = r_pac_x;
   assign pac_y     = r_pac_y;
   assign pac_rot   = r_pac_rot;
   assign map_x     = r_map_x;
   assign map_y     = r_map_y;
   assign ghost_x   = r_ghost_x;
   assign ghost_y   = r_ghost_y;
   assign ghost_rot = r_ghost_rot;
   assign done      = r_done;
   assign skip      = r_skip;
   assign overrun   = r_overrun;

endmodule

// File: doc/sprite_fetch.md
SPRITE_FETCH -- requirements
Module: sprite_fetch

Interface
REQ-001 Parameter WORK_DONE_ADDR, default 17, SHALL be the sprite register index read as the frame-ready flag.
REQ-002 Parameter LAST_ADDR, default 16, SHALL be the last sprite register index fetched; the fetch range is 0..LAST_ADDR.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1 bit, SHALL be the reset: asynchronous, active-low.
REQ-005 Port vblank_start, input, 1 bit, SHALL be a one-cycle pulse that starts a frame fetch.
REQ-006 Port bus_req, output, 1 bit, SHALL request the sprite register read port.
REQ-007 Port bus_gnt, input, 1 bit, SHALL grant the read port; a read completes on any edge with bus_req=1 and bus_gnt=1.
REQ-008 Port reg_addr, output, 6 bits, SHALL drive the sprite register address; bit 5 is always 0.
REQ-009 Port reg_data, input, 8 bits, SHALL carry the combinational read data for reg_addr, valid in the same cycle.
REQ-010 Ports pac_x, pac_y, map_x, map_y, outputs, 8 bits each, SHALL hold registers 0, 1, 3 and 4.
REQ-011 Port pac_rot, output, 2 bits, SHALL hold register 2 bits [1:0].
REQ-012 Ports ghost_x, ghost_y, outputs, 32 bits each, SHALL hold ghost i (0 Blinky, 1 Pinky, 2 Inky, 3 Clyde) in bits [8i+7:8i], sourced from registers 5+3i and 6+3i.
REQ-013 Port ghost_rot, output, 8 bits, SHALL hold ghost i in bits [2i+1:2i], sourced from register 7+3i bits [1:0].
REQ-014 Ports busy, done, skip, overrun, outputs, 1 bit each, SHALL be the status flags defined below.

Function
REQ-015 The FSM SHALL have states IDLE, CHECK, FETCH and COMMIT.
REQ-016 IDLE: bus_req=0, reg_addr=0, busy=0; vblank_start=1 SHALL move to CHECK.
REQ-017 CHECK: bus_req=1, reg_addr=WORK_DONE_ADDR; on a granted edge, reg_data=0 SHALL move to IDLE with skip=1 for the next cycle, and nonzero SHALL move to FETCH with idx=0.
REQ-018 FETCH: bus_req=1, reg_addr=idx; on a granted edge reg_data SHALL be stored in shadow[idx], and idx SHALL increment, or the FSM SHALL move to COMMIT when idx=LAST_ADDR.
REQ-019 When bus_gnt=0 in CHECK or FETCH, state, idx and reg_addr SHALL hold and bus_req SHALL stay 1.
REQ-020 COMMIT: bus_req=0; on the next edge all sprite outputs SHALL load from shadow simultaneously, done=1 for that one cycle, and the FSM SHALL return to IDLE.
REQ-021 busy SHALL be 1 in CHECK, FETCH and COMMIT.
REQ-022 Sprite outputs SHALL change only on the COMMIT edge; a partial or skipped fetch never alters them.
REQ-023 With bus_gnt held at 1, done SHALL assert exactly 19 cycles after the edge that samples vblank_start.
REQ-024 A vblank_start pulse sampled in a state other than IDLE SHALL be ignored, and overrun SHALL be 1 for the following cycle.
REQ-025 done, skip and overrun SHALL be registered single-cycle pulses.
REQ-026 idx SHALL be 5 bits and SHALL never exceed LAST_ADDR.
REQ-027 Register 2 bits [7:2] and register 7+3i bits [7:2] SHALL be discarded.

Reset
REQ-028 While rst_n=0, the FSM SHALL be in IDLE, idx and shadow SHALL be 0, and all outputs, including every sprite output and flag, SHALL be 0.
REQ-029 Reset asserted mid-fetch SHALL abort the fetch immediately (bus_req=0 asynchronously) and discard the shadow contents.
REQ-030 After rst_n rises, no fetch SHALL start until the next vblank_start.

Verification
REQ-031 Happy path: regs 0..16 = 0x10..0x20, reg17=1, gnt=1, pulse vblank_start -> done 19 cycles later; pac_x=0x10, pac_rot=2'b10 (0x12), map_y=0x14, ghost_x[31:24]=0x1E, ghost_rot[7:6]=2'b00 (0x20).
REQ-032 Skip: reg17=0, pulse vblank_start -> one CHECK read, skip=1 for one cycle, no done, outputs unchanged.
REQ-033 Stall: drop gnt for 5 cycles at idx=7 -> reg_addr holds 7 and bus_req stays 1, done arrives at 24 cycles, values correct.
REQ-034 Overrun: second vblank_start during FETCH -> overrun=1 for one cycle, exactly one done, no second fetch.
REQ-035 Reset mid-fetch: rst_n=0 at idx=9 after a prior committed frame -> outputs 0 and bus_req 0 at once; after release, a new vblank_start completes a clean fetch.
